// File: rtl/gba_bus_pkg.sv
// Shared types and helpers for the GBA Game Pak ROM bus slave.
package gba_bus_pkg;

  localparam int GBA_ADDR_W = 24;
  localparam int GBA_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_READY,
    ST_DRIVE
  } gba_rom_state_e;

  // Sequential bursts only carry into the low 16 bits; A[7:0] stays put.
  function automatic logic [GBA_ADDR_W-1:0] gba_addr_inc(input logic [GBA_ADDR_W-1:0] a);
    return {a[GBA_ADDR_W-1:16], a[15:0] + 16'd1};
  endfunction

endpackage

// File: rtl/gba_sync.sv
// N-flop synchroniser for an idle-high async strobe, with one-cycle rise/fall pulses.
module gba_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < N; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[N-1];
    end
  end

  assign q_o    = sync_q[N-1];
  assign rise_o = ~prev_q & q_o;
  assign fall_o = prev_q & ~q_o;

endmodule

// File: rtl/gba_rom_bus.sv
// Game Pak ROM-bus slave: synchronises GBA strobes, fetches halfwords from a backend.
// Optional GBA_ROM_PREFETCH_EN: fetch addr+1 while driving, into a one-entry buffer.
module gba_rom_bus
  import gba_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = GBA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gba_ncs,
  input  logic              gba_nrd,
  input  logic              gba_nwr,
  input  logic [15:0]       gba_ad_i,
  input  logic [7:0]        gba_a_i,
  output logic [15:0]       gba_ad_o,
  output logic              gba_ad_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_valid,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       miss_cnt
);

  logic ncs_s, ncs_rise, ncs_fall;
  logic nrd_s, nrd_rise, nrd_fall;
  logic nwr_s, nwr_rise, nwr_fall;

  gba_sync #(.N(SYNC_STAGES)) u_sync_ncs (.clk(clk), .rst(rst), .d_i(gba_ncs),
    .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall));
  gba_sync #(.N(SYNC_STAGES)) u_sync_nrd (.clk(clk), .rst(rst), .d_i(gba_nrd),
    .q_o(nrd_s), .rise_o(nrd_rise), .fall_o(nrd_fall));
  gba_sync #(.N(SYNC_STAGES)) u_sync_nwr (.clk(clk), .rst(rst), .d_i(gba_nwr),
    .q_o(nwr_s), .rise_o(nwr_rise), .fall_o(nwr_fall));

  logic unused_sync;
  assign unused_sync = ^{ncs_s, nwr_rise, nwr_fall};

  // Address pads delayed to line up with the synchronised nCS fall pulse.
  logic [SYNC_STAGES-1:0][ADDR_W-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= {gba_a_i, gba_ad_i};
      for (int i = 1; i < SYNC_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  gba_rom_state_e    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       buf_q, buf_d;
  logic [15:0]       ad_q, ad_d;
  logic              oe_q, oe_d;
  logic [15:0]       miss_q, miss_d;
  logic [1:0]        drop_q, drop_d;
  logic              accept, valid_live, miss_inc, drop_inc, drop_dec, pf_pend;

`ifdef GBA_ROM_PREFETCH_EN
  logic        pf_acc_q, pf_acc_d;
  logic        pf_full_q, pf_full_d;
  logic [15:0] pf_buf_q, pf_buf_d;
  logic        pf_req;

  assign pf_req   = (state_q == ST_DRIVE) & ~pf_acc_q & ~pf_full_q;
  assign mem_req  = (state_q == ST_FETCH) | pf_req;
  assign mem_addr = (state_q == ST_DRIVE) ? gba_addr_inc(addr_q) : addr_q;
  assign pf_pend  = pf_acc_q;
`else
  assign mem_req  = (state_q == ST_FETCH);
  assign mem_addr = addr_q;
  assign pf_pend  = 1'b0;
`endif

  assign accept     = mem_req & mem_ready;
  // drop_q counts accepted fetches whose data belongs to an aborted burst.
  assign drop_dec   = mem_valid & (drop_q != 2'd0);
  assign valid_live = mem_valid & (drop_q == 2'd0);
  assign drop_inc   = ncs_rise &
                      (accept | (((state_q == ST_WAIT) | pf_pend) & ~valid_live));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    ad_d     = ad_q;
    oe_d     = oe_q;
    miss_inc = 1'b0;
    drop_d   = drop_q - {1'b0, drop_dec} + {1'b0, drop_inc};
`ifdef GBA_ROM_PREFETCH_EN
    pf_acc_d  = pf_acc_q;
    pf_full_d = pf_full_q;
    pf_buf_d  = pf_buf_q;
`endif
    if (ncs_rise) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
`ifdef GBA_ROM_PREFETCH_EN
      pf_acc_d  = 1'b0;
      pf_full_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ncs_fall) begin
            state_d  = ST_FETCH;
            addr_d   = pipe_q[SYNC_STAGES-1];
            miss_inc = nrd_fall;
          end
        end
        ST_FETCH: begin
          miss_inc = nrd_fall;
          if (accept) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          miss_inc = nrd_fall;
          if (valid_live) begin
            if (!nrd_s) begin
              state_d = ST_DRIVE;
              ad_d    = mem_rdata;
              oe_d    = 1'b1;
            end else begin
              state_d = ST_READY;
              buf_d   = mem_rdata;
            end
          end
        end
        ST_READY: begin
          if (nrd_fall) begin
            state_d = ST_DRIVE;
            ad_d    = buf_q;
            oe_d    = 1'b1;
          end
        end
        ST_DRIVE: begin
`ifdef GBA_ROM_PREFETCH_EN
          if (accept) pf_acc_d = 1'b1;
          if (valid_live && pf_acc_q) begin
            pf_acc_d  = 1'b0;
            pf_full_d = 1'b1;
            pf_buf_d  = mem_rdata;
          end
          if (nrd_rise) begin
            oe_d      = 1'b0;
            addr_d    = gba_addr_inc(addr_q);
            pf_acc_d  = 1'b0;
            pf_full_d = 1'b0;
            if (pf_full_q) begin
              state_d = ST_READY;
              buf_d   = pf_buf_q;
            end else if (pf_acc_q && valid_live) begin
              state_d = ST_READY;
              buf_d   = mem_rdata;
            end else if (pf_acc_q || accept) begin
              state_d = ST_WAIT;
            end else begin
              state_d = ST_FETCH;
            end
          end
`else
          if (nrd_rise) begin
            oe_d    = 1'b0;
            addr_d  = gba_addr_inc(addr_q);
            state_d = ST_FETCH;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
    miss_d = (miss_inc && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      buf_q   <= '0;
      ad_q    <= '0;
      oe_q    <= 1'b0;
      miss_q  <= '0;
      drop_q  <= '0;
`ifdef GBA_ROM_PREFETCH_EN
      pf_acc_q  <= 1'b0;
      pf_full_q <= 1'b0;
      pf_buf_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      ad_q    <= ad_d;
      oe_q    <= oe_d;
      miss_q  <= miss_d;
      drop_q  <= drop_d;
`ifdef GBA_ROM_PREFETCH_EN
      pf_acc_q  <= pf_acc_d;
      pf_full_q <= pf_full_d;
      pf_buf_q  <= pf_buf_d;
`endif
    end
  end

  // A host write cycle must never see the pads driven.
  assign gba_ad_oe = oe_q & nwr_s;
  assign gba_ad_o  = ad_q;
  assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_gba_rom_bus.sv
// Directed bench for gba_rom_bus with a single-outstanding backend model.
module tb_gba_rom_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gba_ncs = 1'b1, gba_nrd = 1'b1, gba_nwr = 1'b1;
  logic [15:0] gba_ad_i = '0;
  logic [7:0]  gba_a_i = '0;
  logic [15:0] gba_ad_o;
  logic        gba_ad_oe;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ready = 1'b1;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] miss_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 3;

  gba_rom_bus dut (
    .clk(clk), .rst(rst), .gba_ncs(gba_ncs), .gba_nrd(gba_nrd), .gba_nwr(gba_nwr),
    .gba_ad_i(gba_ad_i), .gba_a_i(gba_a_i), .gba_ad_o(gba_ad_o), .gba_ad_oe(gba_ad_oe),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bdata(input logic [23:0] a);
    return (a == 24'h001234) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  // Backend: accepts at the posedge after a negedge sees req&ready, valid `lat` cycles later.
  always begin
    logic [23:0] ba;
    @(negedge clk);
    if (mem_req && mem_ready && !rst) begin
      ba = mem_addr;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      repeat (lat) @(negedge clk);
      mem_valid = 1'b1;
      mem_rdata = bdata(ba);
      @(negedge clk);
      mem_valid = 1'b0;
      mem_ready = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && !mem_req; i++) tick(1);
  endtask

  task automatic wait_oe(input int budget);
    for (int i = 0; i < budget && !gba_ad_oe; i++) tick(1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("rst_oe", 32'(gba_ad_oe), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_ad", 32'(gba_ad_o), 32'd0);

    // Basic read at 0x001234 then sequential advance
    gba_ad_i = 16'h1234; gba_a_i = 8'h00; gba_ncs = 1'b0;
    wait_req(20);
    chk("t2_req", 32'(mem_req), 32'd1);
    chk("t2_addr0", 32'(mem_addr), 32'h001234);
    tick(10);
    chk("t2_idle_oe", 32'(gba_ad_oe), 32'd0);
    gba_nrd = 1'b0; tick(3);
    chk("t2_oe", 32'(gba_ad_oe), 32'd1);
    chk("t2_data", 32'(gba_ad_o), 32'h0000BEEF);
    gba_nrd = 1'b1; tick(3);
    chk("t2_oe_off", 32'(gba_ad_oe), 32'd0);
    wait_req(10);
    chk("t2_addr1", 32'(mem_addr), 32'h001235);
    chk("t2_miss", 32'(miss_cnt), 32'd0);
    tick(10);
    gba_ncs = 1'b1; tick(6);
    chk("t2_end_req", 32'(mem_req), 32'd0);

    // Low-16 wrap keeps A[7:0]
    gba_ad_i = 16'hFFFF; gba_a_i = 8'h12; gba_ncs = 1'b0;
    wait_req(20);
    chk("t3_addr0", 32'(mem_addr), 32'h12FFFF);
    tick(10);
    gba_nrd = 1'b0; tick(3);
    chk("t3_data0", 32'(gba_ad_o), 32'h0000A5A5);
    gba_nrd = 1'b1; tick(3);
    wait_req(10);
    chk("t3_addr1", 32'(mem_addr), 32'h120000);
    tick(10);
    gba_nrd = 1'b0; tick(3);
    chk("t3_oe1", 32'(gba_ad_oe), 32'd1);
    chk("t3_data1", 32'(gba_ad_o), 32'h00005A5A);
    gba_nrd = 1'b1; tick(3);
    gba_ncs = 1'b1; tick(15);

    // Slow backend: nRD falls before data, drive when it arrives
    lat = 100;
    gba_ad_i = 16'h0100; gba_a_i = 8'h00; gba_ncs = 1'b0;
    wait_req(20);
    chk("t4_addr", 32'(mem_addr), 32'h000100);
    tick(10);
    gba_nrd = 1'b0; tick(5);
    chk("t4_miss", 32'(miss_cnt), 32'd1);
    chk("t4_oe_wait", 32'(gba_ad_oe), 32'd0);
    wait_oe(150);
    chk("t4_oe", 32'(gba_ad_oe), 32'd1);
    chk("t4_data", 32'(gba_ad_o), 32'h00005B5A);
    gba_nrd = 1'b1; tick(3);
    chk("t4_oe_off", 32'(gba_ad_oe), 32'd0);
    tick(3);
    gba_ncs = 1'b1; tick(110);

    // nCS rises during WAIT: late data discarded, next fall latches a new address
    lat = 20;
    gba_ad_i = 16'h2000; gba_a_i = 8'h00; gba_ncs = 1'b0;
    wait_req(20);
    tick(3);
    gba_ncs = 1'b1; tick(5);
    chk("t5_req_drop", 32'(mem_req), 32'd0);
    chk("t5_oe0", 32'(gba_ad_oe), 32'd0);
    tick(25);
    chk("t5_oe_late", 32'(gba_ad_oe), 32'd0);
    chk("t5_miss", 32'(miss_cnt), 32'd1);
    lat = 3;
    gba_ad_i = 16'h3000; gba_a_i = 8'h05; gba_ncs = 1'b0;
    wait_req(20);
    chk("t5_addr", 32'(mem_addr), 32'h053000);
    tick(10);
    gba_nrd = 1'b0; tick(3);
    chk("t5_oe", 32'(gba_ad_oe), 32'd1);
    chk("t5_data", 32'(gba_ad_o), 32'h00006A5A);
    gba_nwr = 1'b0; tick(3);
    chk("nwr_oe_forced", 32'(gba_ad_oe), 32'd0);
    gba_nwr = 1'b1; tick(3);
    chk("nwr_oe_back", 32'(gba_ad_oe), 32'd1);
    gba_nrd = 1'b1; tick(3);
    gba_ncs = 1'b1; tick(15);

    // nCS and nRD fall together: address latched, read counted as miss
    gba_ad_i = 16'h0010; gba_a_i = 8'h00;
    gba_ncs = 1'b0; gba_nrd = 1'b0;
    wait_oe(30);
    chk("sim_oe", 32'(gba_ad_oe), 32'd1);
    chk("sim_miss", 32'(miss_cnt), 32'd2);
    chk("sim_data", 32'(gba_ad_o), 32'h00005A4A);
    gba_nrd = 1'b1; tick(3);
    gba_ncs = 1'b1; tick(15);

    // Reset mid-burst releases AD on the next edge
    gba_ad_i = 16'h0020; gba_a_i = 8'h00; gba_ncs = 1'b0;
    wait_req(20);
    tick(10);
    gba_nrd = 1'b0; tick(3);
    chk("mrst_pre_oe", 32'(gba_ad_oe), 32'd1);
    rst = 1'b1; gba_ncs = 1'b1; gba_nrd = 1'b1;
    tick(1);
    chk("mrst_oe", 32'(gba_ad_oe), 32'd0);
    chk("mrst_miss", 32'(miss_cnt), 32'd0);
    chk("mrst_req", 32'(mem_req), 32'd0);
    chk("mrst_ad", 32'(gba_ad_o), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(10);

`ifdef GBA_ROM_PREFETCH_EN
    lat = 5;
    gba_ad_i = 16'h0400; gba_a_i = 8'h00; gba_ncs = 1'b0;
    wait_req(20);
    tick(10);
    for (int i = 0; i < 8; i++) begin
      gba_nrd = 1'b0; tick(3);
      chk("pf_oe", 32'(gba_ad_oe), 32'd1);
      chk("pf_data", 32'(gba_ad_o), 32'((16'h0400 + 16'(i)) ^ 16'h5A5A));
      tick(5);
      gba_nrd = 1'b1; tick(4);
    end
    chk("pf_miss", 32'(miss_cnt), 32'd0);
    gba_ncs = 1'b1; tick(20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
